// File: rtl/crc_gen.sv
// Parameterised CRC generator: folds DATA_W bits per accepted beat, one beat per clock.
// Result is held in RESULT (in_ready low) until out_ready; clear aborts the frame from any state.
module crc_gen #(
    parameter int               CRC_W   = 16,
    parameter int               DATA_W  = 8,
    parameter logic [CRC_W-1:0] POLY    = CRC_W'(16'h1021),
    parameter logic [CRC_W-1:0] INIT    = '1,
    parameter logic [CRC_W-1:0] XOR_OUT = '0,
    parameter bit               REFLECT = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CRC_W-1:0]  out_crc
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] RESULT = 2'd2;

    function automatic logic [CRC_W-1:0] bitrev(input logic [CRC_W-1:0] v);
        logic [CRC_W-1:0] r;
        r = '0;
        for (int i = 0; i < CRC_W; i++) begin
            r[i] = v[CRC_W-1-i];
        end
        return r;
    endfunction

    localparam logic [CRC_W-1:0] POLY_R = bitrev(POLY);

    // Whole beat unrolled into one combinational step; bit order follows REFLECT.
    function automatic logic [CRC_W-1:0] fold(input logic [CRC_W-1:0] c_in,
                                              input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0] c;
        logic             fb;
        c = c_in;
        for (int i = 0; i < DATA_W; i++) begin
            if (REFLECT) begin
                fb = c[0] ^ d[i];
                c  = (c >> 1) ^ (fb ? POLY_R : '0);
            end else begin
                fb = c[CRC_W-1] ^ d[DATA_W-1-i];
                c  = (c << 1) ^ (fb ? POLY : '0);
            end
        end
        return c;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic             accept;

    assign in_ready  = (state_q != RESULT);
    assign out_valid = (state_q == RESULT);
    assign out_crc   = out_valid ? (crc_q ^ XOR_OUT) : '0;
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        if (clear) begin
            state_d = IDLE;
            crc_d   = INIT;
        end else begin
            case (state_q)
                IDLE, BUSY: begin
                    if (accept) begin
                        crc_d   = fold(crc_q, in_data);
                        state_d = in_last ? RESULT : BUSY;
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        crc_d   = INIT;
                    end
                end
                default: begin
                    state_d = IDLE;
                    crc_d   = INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            crc_q   <= INIT;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
        end
    end

endmodule

// File: tb/tb_crc_gen.sv
// Directed bench for crc_gen: four byte-wide configurations share one stimulus bus,
// a bit-serial CRC-32 instance runs alongside; results are checked through a scoreboard.
module tb_crc_gen;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] e3;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n, clear, in_valid, in_last, out_ready;
    logic [7:0]  in_data;
    logic        rdy0, rdy1, rdy2, rdy3;
    logic        ov0, ov1, ov2, ov3;
    logic [15:0] crc0, crc1, crc2;
    logic [31:0] crc3;
    logic        s_vld, s_dat, s_last, s_rdy, s_ov;
    logic [31:0] s_crc;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    crc_gen u0 (.clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy0),
                .in_data(in_data), .in_last(in_last), .out_valid(ov0), .out_ready(out_ready), .out_crc(crc0));
    crc_gen #(.REFLECT(1'b1), .INIT(16'h0000)) u1 (.clk(clk), .reset_n(reset_n), .clear(clear),
                .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data), .in_last(in_last),
                .out_valid(ov1), .out_ready(out_ready), .out_crc(crc1));
    crc_gen #(.REFLECT(1'b1), .XOR_OUT(16'hFFFF)) u2 (.clk(clk), .reset_n(reset_n), .clear(clear),
                .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data), .in_last(in_last),
                .out_valid(ov2), .out_ready(out_ready), .out_crc(crc2));
    crc_gen #(.CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .XOR_OUT(32'hFFFFFFFF),
              .REFLECT(1'b1)) u3 (.clk(clk), .reset_n(reset_n), .clear(clear),
                .in_valid(in_valid), .in_ready(rdy3), .in_data(in_data), .in_last(in_last),
                .out_valid(ov3), .out_ready(out_ready), .out_crc(crc3));
    crc_gen #(.CRC_W(32), .DATA_W(1), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
              .XOR_OUT(32'hFFFFFFFF), .REFLECT(1'b1)) u4 (.clk(clk), .reset_n(reset_n),
                .clear(1'b0), .in_valid(s_vld), .in_ready(s_rdy), .in_data(s_dat), .in_last(s_last),
                .out_valid(s_ov), .out_ready(1'b1), .out_crc(s_crc));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bq_t to_q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Bit-at-a-time reference CRC over a byte stream for any width up to 32.
    function automatic logic [31:0] model(input bq_t d, input int w, input logic [31:0] poly,
                                          input logic [31:0] init, input logic [31:0] xo,
                                          input bit refl);
        logic [31:0] c, mask, rp;
        logic        fb;
        mask = (w == 32) ? 32'hFFFFFFFF : ((32'd1 << w) - 32'd1);
        rp   = '0;
        for (int i = 0; i < w; i++) rp[i] = poly[w-1-i];
        c = init & mask;
        foreach (d[k]) begin
            for (int j = 0; j < 8; j++) begin
                if (refl) begin
                    fb = c[0] ^ d[k][j];
                    c  = (c >> 1) ^ (fb ? rp : 32'd0);
                end else begin
                    fb = c[w-1] ^ d[k][7-j];
                    c  = ((c << 1) & mask) ^ (fb ? poly : 32'd0);
                end
            end
        end
        return (c ^ xo) & mask;
    endfunction

    function automatic exp_t check_vec();
        exp_t e;
        e.e0 = 32'h29B1;
        e.e1 = 32'h2189;
        e.e2 = 32'h906E;
        e.e3 = 32'hCBF43926;
        return e;
    endfunction

    // Entered and left at posedge+1; waits (bounded) while in_ready is low.
    task automatic send_bytes(input bq_t d, input bit last, input int max_gap);
        int n;
        foreach (d[k]) begin
            in_valid = 1'b1;
            in_data  = d[k];
            in_last  = last && (k == d.size() - 1);
            n = 0;
            while (!rdy0 && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 50) chk("in_ready_timeout", 32'(n), 32'd0);
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) begin
                    @(posedge clk); #1;
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (ov0 && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", {16'd0, crc0}, 32'hxxxxxxxx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("crc_default", {16'd0, crc0}, e.e0);
                chk("crc_refl_init0", {16'd0, crc1}, e.e1);
                chk("crc_refl_xor", {16'd0, crc2}, e.e2);
                chk("crc32_byte", crc3, e.e3);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t  vec, rq;
        exp_t e;
        reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        out_ready = 1'b1; s_vld = 1'b0; s_dat = 1'b0; s_last = 1'b0;
        vec = to_q("123456789");

        @(negedge clk);
        chk("reset_out_valid", {31'd0, ov0}, 32'd0);
        chk("reset_out_crc", {16'd0, crc0}, 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_reset", {31'd0, rdy0}, 32'd1);

        // Reference vector on all four configurations, with pulse timing.
        sb.push_back(check_vec());
        send_bytes(vec, 1'b1, 0);
        @(negedge clk);
        chk("pulse_rise", {31'd0, ov0}, 32'd1);
        @(posedge clk); #1;
        chk("pulse_fall", {31'd0, ov0}, 32'd0);
        chk("crc_zero_idle", {16'd0, crc0}, 32'd0);

        // Bit-serial CRC-32, each byte LSB first.
        foreach (vec[k]) begin
            for (int j = 0; j < 8; j++) begin
                s_vld  = 1'b1;
                s_dat  = vec[k][j];
                s_last = (k == 8) && (j == 7);
                @(posedge clk); #1;
            end
        end
        s_vld = 1'b0; s_last = 1'b0;
        @(negedge clk);
        chk("serial_valid", {31'd0, s_ov}, 32'd1);
        chk("crc32_serial", s_crc, 32'hCBF43926);
        @(posedge clk); #1;

        // Output stall with the next frame's first beat waiting.
        out_ready = 1'b0;
        sb.push_back(check_vec());
        send_bytes(vec, 1'b1, 0);
        in_valid = 1'b1; in_data = vec[0]; in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, rdy0}, 32'd0);
            chk("stall_out_crc", {16'd0, crc0}, 32'h29B1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        sb.push_back(check_vec());
        send_bytes(vec, 1'b1, 0);

        // Random frames (including single-beat) with idle gaps against the reference model.
        for (int f = 0; f < 4; f++) begin
            rq.delete();
            repeat ((f == 0) ? 1 : $urandom_range(2, 12)) rq.push_back(8'($urandom));
            e.e0 = model(rq, 16, 32'h1021, 32'hFFFF, 32'h0, 1'b0);
            e.e1 = model(rq, 16, 32'h1021, 32'h0000, 32'h0, 1'b1);
            e.e2 = model(rq, 16, 32'h1021, 32'hFFFF, 32'hFFFF, 1'b1);
            e.e3 = model(rq, 32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
            sb.push_back(e);
            send_bytes(rq, 1'b1, 2);
            @(posedge clk); #1;
        end

        // Clear after four beats, then a full frame.
        send_bytes(to_q("1234"), 1'b0, 0);
        clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        sb.push_back(check_vec());
        send_bytes(vec, 1'b1, 0);
        @(posedge clk); #1;

        // Clear coincident with the last beat: no result.
        send_bytes(to_q("1234"), 1'b0, 0);
        in_valid = 1'b1; in_data = 8'h35; in_last = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        chk("clear_last_no_valid", {31'd0, ov0}, 32'd0);
        chk("clear_last_in_ready", {31'd0, rdy0}, 32'd1);
        sb.push_back(check_vec());
        send_bytes(vec, 1'b1, 0);
        @(posedge clk); #1;

        // Reset mid-frame.
        send_bytes(to_q("1234"), 1'b0, 0);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", {31'd0, ov0}, 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_in_ready", {31'd0, rdy0}, 32'd1);
        sb.push_back(check_vec());
        send_bytes(vec, 1'b1, 0);
        @(posedge clk); #1;

        // Reset while holding a result.
        out_ready = 1'b0;
        send_bytes(vec, 1'b1, 0);
        @(negedge clk);
        chk("result_held", {31'd0, ov0}, 32'd1);
        @(posedge clk); #1 reset_n = 1'b0;
        #1;
        chk("rst_result_out_valid", {31'd0, ov0}, 32'd0);
        chk("rst_result_out_crc", {16'd0, crc0}, 32'd0);
        @(posedge clk); #1 reset_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("rst_result_in_ready", {31'd0, rdy0}, 32'd1);
        sb.push_back(check_vec());
        send_bytes(vec, 1'b1, 0);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
